// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Purpose : Shared definitions for the memory-access stage: global state
//           encodings, inter-stage bus widths and field layout, access-size
//           codes, the stage FSM encoding and a misalignment helper.
// Ports   : none (package)
// Options : MEM_ALIGN_CHECK_EN (consumed by mem_stage, helper lives here)
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Global multicycle state encodings
  localparam logic [3:0] STATE_IF  = 4'd0;
  localparam logic [3:0] STATE_ID  = 4'd1;
  localparam logic [3:0] STATE_EX  = 4'd2;
  localparam logic [3:0] STATE_MEM = 4'd3;
  localparam logic [3:0] STATE_WB  = 4'd4;

  localparam int ES_TO_MS_BUS_WD = 107;
  localparam int MS_TO_WS_BUS_WD = 70;

  // Field offsets (LSB) in the execute-to-memory bus
  localparam int ES_MEM_WE_BIT   = 106;
  localparam int ES_MEM_RE_BIT   = 105;
  localparam int ES_SIZE_LSB     = 103;
  localparam int ES_UNSIGNED_BIT = 102;
  localparam int ES_GR_WE_BIT    = 101;
  localparam int ES_DEST_LSB     = 96;
  localparam int ES_ADDR_LSB     = 64;
  localparam int ES_ST_DATA_LSB  = 32;
  localparam int ES_PC_LSB       = 0;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } ms_fsm_e;

  // Packed view of the execute-to-memory bus, MSB first
  typedef struct packed {
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  size;
    logic        is_unsigned;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] pc;
  } es_bus_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == MEM_SIZE_HALF) && addr_lo[0]) ||
           ((size == MEM_SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_align
// Purpose : Combinational lane logic: store byte strobes, replicated store
//           data and the aligned, sign/zero-extended load result.
// Ports   : size_i, unsigned_i, addr_lo_i, st_data_i, rdata_i (in)
//           wstrb_o, wdata_o, ld_result_o (out)
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wstrb_o     = 4'b1111;
    wdata_o     = st_data_i;
    ld_result_o = rdata_i;
    case (size_i)
      MEM_SIZE_BYTE: begin
        wstrb_o     = 4'b0001 << addr_lo_i;
        wdata_o     = {4{st_data_i[7:0]}};
        ld_result_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
      end
      MEM_SIZE_HALF: begin
        wstrb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o     = {2{st_data_i[15:0]}};
        ld_result_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
      end
      default: ;  // word (size code 3 is treated as word)
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Purpose : Memory-access stage of the multicycle core. Captures a load or
//           store from execute, runs one data-SRAM request/response, aligns
//           load data and hands a result bus to write-back.
// Ports   : clk, resetn (async, active low), state, next_state
//           es_to_ms_valid/bus (from EX), ms_to_ws_valid/bus (to WB)
//           data_sram_* request/response interface
//           ms_ale (only with MEM_ALIGN_CHECK_EN)
// Options : MEM_ALIGN_CHECK_EN - misaligned half/word accesses skip the SRAM
//           and raise ms_ale in the result cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [3:0]                 state,
  output logic [3:0]                 next_state,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [1:0]                 data_sram_size,
  output logic [3:0]                 data_sram_wstrb,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                       ms_ale
`endif
);

  ms_fsm_e     fsm_q, fsm_d;
  es_bus_t     bus_q, bus_d;
  logic [31:0] rdata_q, rdata_d;
  es_bus_t     es_in;
  logic        in_ale;   // incoming access is misaligned
  logic        ale_q;    // held access is misaligned
  logic        in_req;
  logic        st_q;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] ld_result;
  logic [31:0] final_result;

  // Global state is sequenced externally; this stage only reports requests
  logic unused_state;
  assign unused_state = ^state;

  assign es_in = es_bus_t'(es_to_ms_bus);

`ifdef MEM_ALIGN_CHECK_EN
  assign in_ale = is_misaligned(es_in.size, es_in.addr[1:0]);
  assign ale_q  = (bus_q.mem_we | bus_q.mem_re) && is_misaligned(bus_q.size, bus_q.addr[1:0]);
  assign ms_ale = (fsm_q == MS_DONE) && ale_q;
`else
  assign in_ale = 1'b0;
  assign ale_q  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= MS_IDLE;
      bus_q   <= '0;
      rdata_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    bus_d   = bus_q;
    rdata_d = rdata_q;
    case (fsm_q)
      MS_IDLE: begin
        // Non-memory ops are latched too but never leave IDLE
        if (es_to_ms_valid) begin
          bus_d = es_in;
          if (es_in.mem_we | es_in.mem_re) begin
            fsm_d = in_ale ? MS_DONE : MS_REQ;
          end
        end
      end
      MS_REQ: begin
        // data_ok here would violate the slave protocol and is ignored
        if (data_sram_addr_ok) begin
          fsm_d = MS_WAIT;
        end
      end
      MS_WAIT: begin
        if (data_sram_data_ok) begin
          rdata_d = data_sram_rdata;
          fsm_d   = MS_DONE;
        end
      end
      MS_DONE: fsm_d = MS_IDLE;
      default: fsm_d = MS_IDLE;
    endcase
  end

  mem_stage_align u_align (
    .size_i      (bus_q.size),
    .unsigned_i  (bus_q.is_unsigned),
    .addr_lo_i   (bus_q.addr[1:0]),
    .st_data_i   (bus_q.st_data),
    .rdata_i     (rdata_q),
    .wstrb_o     (wstrb),
    .wdata_o     (wdata),
    .ld_result_o (ld_result)
  );

  // Request fields come straight from the held bus, so they stay stable
  // for every cycle spent in REQ; they read as zero outside REQ.
  assign in_req          = (fsm_q == MS_REQ);
  assign st_q            = in_req & bus_q.mem_we;
  assign data_sram_req   = in_req;
  assign data_sram_wr    = st_q;
  assign data_sram_size  = in_req ? bus_q.size : 2'b00;
  assign data_sram_addr  = in_req ? bus_q.addr : 32'd0;
  assign data_sram_wstrb = st_q ? wstrb : 4'b0000;
  assign data_sram_wdata = st_q ? wdata : 32'd0;

  assign final_result   = (bus_q.mem_re && !ale_q) ? ld_result : bus_q.addr;
  assign ms_to_ws_valid = (fsm_q == MS_DONE);
  assign ms_to_ws_bus   = {bus_q.gr_we & ~ale_q, bus_q.dest, final_result, bus_q.pc};
  assign next_state     = (fsm_q == MS_DONE) ? STATE_WB : STATE_MEM;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage
// Purpose : Self-checking bench for mem_stage: directed and random loads and
//           stores against a random-latency SRAM slave, with a reference
//           model feeding a scoreboard that a separate monitor drains.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   state;
  logic [3:0]   next_state;
  logic         es_to_ms_valid;
  logic [106:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic         data_sram_req, data_sram_wr;
  logic [1:0]   data_sram_size;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic         data_sram_addr_ok, data_sram_data_ok;
`ifdef MEM_ALIGN_CHECK_EN
  logic         ms_ale;
`endif

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk               (clk),
    .resetn            (resetn),
    .state             (state),
    .next_state        (next_state),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .ms_ale          (ms_ale)
`endif
  );

  typedef struct { logic [69:0] bus; logic ale; int lat; } exp_out_t;
  typedef struct { logic wr; logic [1:0] size; logic [31:0] addr, wdata; logic [3:0] wstrb; } exp_req_t;
  typedef struct { logic is_load; logic [1:0] size; logic uns; logic [4:0] dest;
                   logic [31:0] addr, pc; int lat; } txn_t;

  exp_out_t out_q[$];
  exp_req_t req_q[$];
  txn_t     pend_q[$];

  int n_tests = 0, n_fail = 0, n_done = 0;
  int cyc = 0, issue_cyc = 0;
  int addr_wait = -1, data_wait = -1;
  bit flush_resp = 0;
  bit force_en = 0;
  logic [31:0] force_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string got, input string need);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %s, required %s", name, got, need);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sw;
    int                 ext;
    if (size == 2'd0) begin
      sh = rdata >> (8 * addr[1:0]);
      sb = sh[7:0];
      ext = sb;
      return uns ? {24'd0, sh[7:0]} : 32'(ext);
    end else if (size == 2'd1) begin
      sh = rdata >> (16 * addr[1]);
      sw = sh[15:0];
      ext = sw;
      return uns ? {16'd0, sh[15:0]} : 32'(ext);
    end
    return rdata;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << addr[1:0]);
    if (size == 2'd1) return 4'(3 << (addr[1:0] & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
    int nb;
    nb = 1 << size;
    return (int'(addr[1:0]) % nb) != 0;
  endfunction

  // ---------------- SRAM slave ----------------
  initial begin : slave
    txn_t     cur;
    exp_out_t o;
    int       req_cycles, cur_wait, resp_cnt;
    logic [31:0] rd;
    req_cycles = 0; cur_wait = 0; resp_cnt = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      data_sram_addr_ok = 0;
      data_sram_data_ok = 0;
      data_sram_rdata   = $urandom;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          rd = force_en ? force_val : $urandom;
          data_sram_rdata   = rd;
          data_sram_data_ok = 1;
          if (flush_resp) flush_resp = 0;
          else begin
            o.bus = {cur.is_load, cur.dest,
                     cur.is_load ? model_load(cur.size, cur.uns, cur.addr, rd) : cur.addr, cur.pc};
            o.ale = 0;
            o.lat = cur.lat;
            out_q.push_back(o);
          end
        end
      end
      if (data_sram_req === 1'b1) begin
        if (req_cycles == 0) cur_wait = (addr_wait >= 0) ? addr_wait : $urandom_range(0, 3);
        req_cycles++;
        if (req_cycles > cur_wait) begin
          data_sram_addr_ok = 1;
          req_cycles = 0;
          resp_cnt = (data_wait >= 0) ? data_wait : $urandom_range(1, 3);
          if (pend_q.size() > 0) cur = pend_q.pop_front();
        end else if ($urandom_range(0, 3) == 0) begin
          data_sram_data_ok = 1;  // early data_ok must be ignored
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_out_t e;
    exp_req_t r;
    bit prev_valid;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      #2;
      if (resetn === 1'b1) begin
        if (data_sram_req === 1'b1) begin
          if (req_q.size() == 0) flag("unexpected_req", "request", "no request");
          else begin
            r = req_q[0];
            check("req_hdr", {data_sram_wr, data_sram_size, data_sram_addr}, {r.wr, r.size, r.addr});
            if (r.wr) begin
              check("req_wstrb", data_sram_wstrb, r.wstrb);
              check("req_wdata", data_sram_wdata, r.wdata);
            end
            if (data_sram_addr_ok) void'(req_q.pop_front());
          end
        end
        if (ms_to_ws_valid === 1'b1) begin
          n_done++;
          if (prev_valid) flag("valid_pulse", "2-cycle valid", "1-cycle valid");
          if (out_q.size() == 0) flag("unexpected_valid", "ms_to_ws_valid", "none");
          else begin
            e = out_q.pop_front();
            check("ws_bus", ms_to_ws_bus, e.bus);
            check("next_state_wb", next_state, STATE_WB);
            if (e.lat >= 0) check("latency", 32'(cyc - issue_cyc), 32'(e.lat));
`ifdef MEM_ALIGN_CHECK_EN
            check("ms_ale", ms_ale, e.ale);
`endif
          end
        end else begin
          check("next_state_mem", next_state, STATE_MEM);
`ifdef MEM_ALIGN_CHECK_EN
          check("ms_ale_idle", ms_ale, 1'b0);
`endif
        end
        prev_valid = (ms_to_ws_valid === 1'b1);
      end else prev_valid = 0;
    end
  end

  // ---------------- driver ----------------
  // mode 0: normal, 1: spurious capture during REQ, 2: reset in WAIT, 3: non-memory op
  task automatic issue(input int mode, input bit is_load, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] st, input int lat);
    txn_t t; exp_req_t r; exp_out_t o; logic [106:0] bus; bit ale; int start; bit seen;
    t.is_load = is_load; t.size = size; t.uns = uns; t.dest = 5'($urandom);
    t.addr = addr; t.pc = $urandom; t.lat = lat;
    bus = {(mode != 3) && !is_load, (mode != 3) && is_load, size, uns, is_load, t.dest, addr, st, t.pc};
    ale = 0;
`ifdef MEM_ALIGN_CHECK_EN
    ale = (mode != 3) && misaligned(size, addr);
`endif
    if (mode != 3) begin
      if (ale) begin
        o.bus = {1'b0, t.dest, addr, t.pc}; o.ale = 1; o.lat = lat;
        out_q.push_back(o);
      end else begin
        r.wr = !is_load; r.size = size; r.addr = addr;
        r.wdata = model_wdata(size, st); r.wstrb = model_wstrb(size, addr);
        req_q.push_back(r);
        pend_q.push_back(t);
      end
    end
    start = n_done;
    @(negedge clk);
    es_to_ms_valid = 1; es_to_ms_bus = bus;
    @(negedge clk);
    es_to_ms_valid = 0; es_to_ms_bus = 107'({$urandom, $urandom, $urandom, $urandom});
    issue_cyc = cyc;
    if (mode == 3) begin
      repeat (3) @(negedge clk);
      return;
    end
    if (mode == 1) begin
      @(negedge clk);
      es_to_ms_valid = 1;
      es_to_ms_bus = {2'b10, 9'($urandom), 32'h0000_3000, 32'($urandom), 32'($urandom)};
      @(negedge clk);
      es_to_ms_valid = 0;
    end
    if (mode == 2) begin
      @(negedge clk);
      #3;
      flush_resp = 1;
      resetn = 0;
      #1;
      check("rst_req", data_sram_req, 1'b0);
      check("rst_valid", ms_to_ws_valid, 1'b0);
      check("rst_next_state", next_state, STATE_MEM);
      @(negedge clk);
      #3;
      resetn = 1;
      repeat (6) @(negedge clk);
      return;
    end
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (n_done != start) seen = 1;
    end
    if (!seen) flag("timeout", "no ms_to_ws_valid in 200 cycles", "one result");
  endtask

  initial begin : main
    bit ld; logic [1:0] sz; logic [31:0] a; int kind;
    resetn = 0; state = STATE_MEM; es_to_ms_valid = 0; es_to_ms_bus = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_next_state", next_state, STATE_MEM);
    check("reset_req", {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb}, 0);
    check("reset_addr_wdata", {data_sram_addr, data_sram_wdata}, 0);
    check("reset_ws", {ms_to_ws_valid, ms_to_ws_bus}, 0);
    @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);

    // zero-wait directed accesses
    addr_wait = 0; data_wait = 1; force_en = 1;
    force_val = 32'hDEAD_BEEF;
    issue(0, 1, 2'd2, 0, 32'h0000_1000, 32'd0, 2);
    force_val = 32'h8012_3456;
    issue(0, 1, 2'd0, 0, 32'h0000_1003, 32'd0, 2);
    issue(0, 1, 2'd0, 1, 32'h0000_1003, 32'd0, 2);
    issue(0, 1, 2'd1, 0, 32'h0000_1002, 32'd0, 2);
    issue(0, 0, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 2);

    // stalled slave with a spurious capture attempt during REQ
    addr_wait = 5; data_wait = 3;
    issue(1, 1, 2'd2, 0, 32'h0000_1004, 32'd0, 9);

    // reset while waiting for data, late data_ok after release
    addr_wait = 0; data_wait = 4;
    issue(2, 1, 2'd2, 0, 32'h0000_1008, 32'd0, -1);

`ifdef MEM_ALIGN_CHECK_EN
    addr_wait = 0; data_wait = 1;
    issue(0, 1, 2'd2, 0, 32'h0000_1001, 32'd0, 0);
`endif

    // random traffic
    addr_wait = -1; data_wait = -1; force_en = 0;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      ld   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 2));
      a    = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
`endif
      issue((kind == 0) ? 3 : 0, ld, sz, 1'($urandom_range(0, 1)), a, $urandom, -1);
    end

    repeat (5) @(negedge clk);
    check("out_q_drained", 70'(out_q.size()), 70'd0);
    check("req_q_drained", 70'(req_q.size()), 70'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the multicycle LoongArch core. It sits between the execute stage and the write-back stage. It is active only while the global state is STATE_MEM, and only for load and store instructions; execute forwards all other instructions straight to write-back. It runs one data-SRAM request/response transaction, aligns and extends load data, then hands a 70-bit result bus to write-back and steers the global state to STATE_WB.

Parameters:
- ES_TO_MS_BUS_WD, 107, width of the execute-to-memory bus.
- MS_TO_WS_BUS_WD, 70, width of the memory-to-write-back bus.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- state  in  4  global state (STATE_* encodings).
- next_state  out  4  requested next global state.
- es_to_ms_valid  in  1  bus-capture strobe from execute.
- es_to_ms_bus  in  107  fields, MSB to LSB:
  - mem_we[106], mem_re[105], mem_size[104:103] (0=byte, 1=half, 2=word), mem_unsigned[102]
  - gr_we[101], dest[100:96], alu_result/addr[95:64], st_data[63:32], pc[31:0]
- ms_to_ws_valid  out  1  one-cycle result strobe to write-back.
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- data_sram_req  out  1  request valid.
- data_sram_wr  out  1  1 = store.
- data_sram_size  out  2  access size.
- data_sram_wstrb  out  4  byte strobes.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  store data.
- data_sram_addr_ok  in  1  request accepted.
- data_sram_data_ok  in  1  response or write-complete.
- data_sram_rdata  in  32  load data.

Behaviour:
- Reset values:
  - FSM = IDLE; bus register = 0; rdata register = 0.
  - All outputs 0, except next_state = STATE_MEM.
- Capture: at a posedge with es_to_ms_valid=1, latch es_to_ms_bus. If mem_we|mem_re, the FSM moves to REQ.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: no request.
  - REQ: data_sram_req=1. Hold all request fields stable until a cycle with addr_ok=1, then go to WAIT.
  - WAIT: wait for data_ok=1. On data_ok, register rdata and go to DONE. A data_ok sampled in REQ is a protocol error and is ignored; the slave never asserts data_ok before the cycle after addr_ok.
  - DONE: ms_to_ws_valid=1 for exactly one cycle, then go to IDLE.
- next_state: STATE_WB in DONE, otherwise STATE_MEM.
- Zero-wait latency: 3 cycles in STATE_MEM (REQ, WAIT, DONE).
- Stores:
  - wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
  - wdata: byte = {4{st_data[7:0]}}; half = {2{st_data[15:0]}}; word = st_data.
  - ms_to_ws_bus carries gr_we as decoded (0 for stores).
- Load final_result:
  - Byte: lane addr[1:0]; sign- or zero-extended per mem_unsigned.
  - Half: lane addr[1]; sign- or zero-extended per mem_unsigned.
  - Word: rdata unchanged.
- Store final_result = alu_result.
- Load and store request the same address: data_sram_addr = alu_result (low bits unmasked).
- Simultaneous events: es_to_ms_valid while the FSM is not IDLE is ignored, because the global state machine guarantees exclusivity.
- Asynchronous reset mid-transaction: data_sram_req drops immediately, the FSM returns to IDLE, and any in-flight response is dropped.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) skips REQ/WAIT; the FSM goes capture → DONE.
  - The bus is forwarded with gr_we forced to 0 and final_result = addr.
  - Extra output ms_ale (1 bit) is high during that DONE cycle.
- Undefined: no check is made, no ms_ale port exists, and low address bits pass through unchanged.

Decomposition:
- Shared package/header (head.h):
  - STATE_* encodings.
  - Bus widths and field offsets.
  - MEM_SIZE_BYTE/HALF/WORD constants.
  - FSM state encodings.
- Sub-module: mem_align, purely combinational. It computes wstrb, replicated wdata and the extended load result from size, unsigned, addr[1:0], st_data and rdata.

Test Plan:
- ld.w at addr 0x1000, zero-wait slave, rdata 0xDEADBEEF → req for 1 cycle, ms_to_ws_valid in the 3rd cycle, bus {1, dest, 0xDEADBEEF, pc}, next_state=STATE_WB in DONE only.
- ld.b at 0x1003, rdata 0x80123456, signed → result 0xFFFFFF80; ld.bu at the same address → 0x00000080; ld.h at 0x1002 → 0xFFFF8012.
- st.h at 0x2002, st_data 0x0000ABCD → wstrb 4'b1100, wdata 0xABCDABCD, wr=1, gr_we=0 on the output bus.
- addr_ok held low 5 cycles, then data_ok 3 cycles after acceptance → req and fields stable for all 6 REQ cycles, single ms_to_ws_valid pulse, no duplicate request.
- resetn asserted during WAIT → req=0, ms_to_ws_valid=0, next_state=STATE_MEM immediately; a late data_ok after release causes no output.
- With MEM_ALIGN_CHECK_EN: ld.w at 0x1001 → no data_sram_req, ms_ale=1 and gr_we=0 in the DONE cycle.
